// File: rtl/output_source_ctrl.sv
// Output source controller: chooses DTU, ATU or idle words for the serializers.
// Sources change only on handshakes, with an idle gap inserted at every switch.
module output_source_ctrl #(
    parameter logic [31:0] IDLE_WORD  = 32'hEAAAAAAA,
    parameter int unsigned N_IDLE     = 4,
    parameter int unsigned HS_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        rst_b,
    input  logic        handshake,
    input  logic        TEST_ENABLE,
    input  logic        CALIBRATION_BUSY_1,
    input  logic        CALIBRATION_BUSY_10,
    input  logic [31:0] DATA32_DTU_0,
    input  logic [31:0] DATA32_DTU_1,
    input  logic [31:0] DATA32_DTU_2,
    input  logic [31:0] DATA32_DTU_3,
    input  logic [31:0] DATA32_ATU_0,
    input  logic [31:0] DATA32_ATU_1,
    input  logic [31:0] DATA32_ATU_2,
    input  logic [31:0] DATA32_ATU_3,
    output logic [31:0] DATA32_0,
    output logic [31:0] DATA32_1,
    output logic [31:0] DATA32_2,
    output logic [31:0] DATA32_3,
    output logic [1:0]  src_sel,
    output logic        switch_busy,
    output logic        sync_err
);

    typedef enum logic [1:0] {
        ST_DTU,
        ST_ATU,
        ST_CALIB,
        ST_SWITCH
    } state_t;

    localparam logic [2:0] IDLE_LOAD = 3'(N_IDLE - 1);
    localparam logic [6:0] WD_MAX    = 7'(HS_TIMEOUT);
    localparam logic [1:0] SEL_DTU   = 2'b00;
    localparam logic [1:0] SEL_ATU   = 2'b01;
    localparam logic [1:0] SEL_IDLE  = 2'b10;

    state_t      state_q, state_d;
    logic [2:0]  idle_cnt_q, idle_cnt_d;
    logic [6:0]  wd_cnt_q, wd_cnt_d;
    logic [1:0]  sel_d;
    logic        cal;
    logic [31:0] dtu_w [4];
    logic [31:0] atu_w [4];
    logic [31:0] out_q [4];

    assign cal = CALIBRATION_BUSY_1 | CALIBRATION_BUSY_10;

    assign dtu_w[0] = DATA32_DTU_0;
    assign dtu_w[1] = DATA32_DTU_1;
    assign dtu_w[2] = DATA32_DTU_2;
    assign dtu_w[3] = DATA32_DTU_3;
    assign atu_w[0] = DATA32_ATU_0;
    assign atu_w[1] = DATA32_ATU_1;
    assign atu_w[2] = DATA32_ATU_2;
    assign atu_w[3] = DATA32_ATU_3;

    assign DATA32_0 = out_q[0];
    assign DATA32_1 = out_q[1];
    assign DATA32_2 = out_q[2];
    assign DATA32_3 = out_q[3];

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        if (handshake) begin
            unique case (state_q)
                ST_DTU: begin
                    if (cal)              state_d = ST_CALIB;
                    else if (TEST_ENABLE) state_d = ST_SWITCH;
                end
                ST_ATU: begin
                    if (cal)               state_d = ST_CALIB;
                    else if (!TEST_ENABLE) state_d = ST_SWITCH;
                end
                ST_CALIB: begin
                    if (!cal) state_d = ST_SWITCH;
                end
                ST_SWITCH: begin
                    // exit target is decided only when the count runs out
                    if (idle_cnt_q != 3'd0) idle_cnt_d = idle_cnt_q - 3'd1;
                    else if (cal)           state_d = ST_CALIB;
                    else if (TEST_ENABLE)   state_d = ST_ATU;
                    else                    state_d = ST_DTU;
                end
                default: state_d = ST_DTU;
            endcase
            if (state_d == ST_SWITCH && state_q != ST_SWITCH)
                idle_cnt_d = IDLE_LOAD;
        end
    end

    always_comb begin
        sel_d = SEL_IDLE;
        unique case (1'b1)
            state_d == ST_DTU: sel_d = SEL_DTU;
            state_d == ST_ATU: sel_d = SEL_ATU;
            default:           sel_d = SEL_IDLE;
        endcase
    end

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (handshake)             wd_cnt_d = 7'd0;
        else if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + 7'd1;
    end

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            state_q     <= ST_DTU;
            idle_cnt_q  <= 3'd0;
            wd_cnt_q    <= 7'd0;
            src_sel     <= SEL_IDLE;
            switch_busy <= 1'b0;
            sync_err    <= 1'b0;
            for (int i = 0; i < 4; i++) out_q[i] <= IDLE_WORD;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            sync_err   <= sync_err | (wd_cnt_d == WD_MAX);
            if (handshake) begin
                src_sel     <= sel_d;
                switch_busy <= (state_d == ST_SWITCH);
                for (int i = 0; i < 4; i++) begin
                    unique case (sel_d)
                        SEL_DTU: out_q[i] <= dtu_w[i];
                        SEL_ATU: out_q[i] <= atu_w[i];
                        default: out_q[i] <= IDLE_WORD;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_output_source_ctrl.sv
// Scoreboard bench for output_source_ctrl: directed handshake sequences
// push expected words; a monitor checks every cycle's outputs.
module tb_output_source_ctrl;

    localparam logic [31:0] IDLE = 32'hEAAAAAAA;

    typedef enum {K_DTU, K_ATU, K_CAL, K_SW} kind_e;

    typedef struct packed {
        logic [3:0][31:0] d;
        logic [1:0]       sel;
        logic             busy;
    } exp_t;

    logic        CLK = 1'b0;
    logic        rst_b = 1'b0;
    logic        handshake = 1'b0;
    logic        TEST_ENABLE = 1'b0;
    logic        cal1 = 1'b0;
    logic        cal10 = 1'b0;
    logic [31:0] dtu [4];
    logic [31:0] atu [4];
    logic [31:0] d0, d1, d2, d3;
    logic [1:0]  src_sel;
    logic        switch_busy;
    logic        sync_err;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q [$];
    exp_t cur;

    always #5 CLK = ~CLK;

    output_source_ctrl dut (
        .CLK                 (CLK),
        .rst_b               (rst_b),
        .handshake           (handshake),
        .TEST_ENABLE         (TEST_ENABLE),
        .CALIBRATION_BUSY_1  (cal1),
        .CALIBRATION_BUSY_10 (cal10),
        .DATA32_DTU_0        (dtu[0]),
        .DATA32_DTU_1        (dtu[1]),
        .DATA32_DTU_2        (dtu[2]),
        .DATA32_DTU_3        (dtu[3]),
        .DATA32_ATU_0        (atu[0]),
        .DATA32_ATU_1        (atu[1]),
        .DATA32_ATU_2        (atu[2]),
        .DATA32_ATU_3        (atu[3]),
        .DATA32_0            (d0),
        .DATA32_1            (d1),
        .DATA32_2            (d2),
        .DATA32_3            (d3),
        .src_sel             (src_sel),
        .switch_busy         (switch_busy),
        .sync_err            (sync_err)
    );

    function automatic exp_t idle_exp();
        exp_t e;
        for (int i = 0; i < 4; i++) e.d[i] = IDLE;
        e.sel  = 2'b10;
        e.busy = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(kind_e k);
        exp_t e;
        for (int i = 0; i < 4; i++)
            e.d[i] = (k == K_DTU) ? dtu[i] : (k == K_ATU) ? atu[i] : IDLE;
        e.sel  = (k == K_DTU) ? 2'b00 : (k == K_ATU) ? 2'b01 : 2'b10;
        e.busy = (k == K_SW);
        return e;
    endfunction

    function void check(string name, exp_t e);
        exp_t a;
        a.d[0] = d0;
        a.d[1] = d1;
        a.d[2] = d2;
        a.d[3] = d3;
        a.sel  = src_sel;
        a.busy = switch_busy;
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h %h %h %h sel=%b busy=%b, expected %h %h %h %h sel=%b busy=%b",
                     name, $time, a.d[0], a.d[1], a.d[2], a.d[3], a.sel, a.busy,
                     e.d[0], e.d[1], e.d[2], e.d[3], e.sel, e.busy);
        end
    endfunction

    function void chk_bit(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endfunction

    always @(posedge CLK) begin : monitor
        logic r_s, h_s;
        r_s = rst_b;
        h_s = handshake;
        #1;
        if (!r_s) begin
            cur = idle_exp();
            check("reset_state", cur);
        end else if (h_s) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard t=%0t: handshake with no expected entry", $time);
            end else begin
                cur = q.pop_front();
                check("handshake_load", cur);
            end
        end else begin
            check("hold_stable", cur);
        end
    end

    task automatic hs(input kind_e k, input int gap = 7);
        handshake = 1'b1;
        q.push_back(mk(k));
        @(negedge CLK);
        handshake = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dtu[i] = dtu[i] + 32'h00010000;
            atu[i] = atu[i] + 32'h00000100;
        end
        repeat (gap) @(negedge CLK);
    endtask

    task automatic hs_n(input kind_e k, input int n, input int gap = 7);
        for (int i = 0; i < n; i++) hs(k, gap);
    endtask

    initial begin
        dtu[0] = 32'h11111111;
        dtu[1] = 32'h22222222;
        dtu[2] = 32'h33333333;
        dtu[3] = 32'h44444444;
        atu[0] = 32'hA0000001;
        atu[1] = 32'hA0000002;
        atu[2] = 32'hA0000003;
        atu[3] = 32'hA0000004;
        cur = idle_exp();

        repeat (2) @(negedge CLK);
        chk_bit("reset_sync_err", sync_err, 1'b0);
        rst_b = 1'b1;
        repeat (3) @(negedge CLK);

        // normal data, words change between handshakes
        hs_n(K_DTU, 2);

        // test switch: 4 idle words then ATU
        TEST_ENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        hs_n(K_SW, 4);
        hs_n(K_ATU, 2);

        // calibration preemption from ATU
        cal10 = 1'b1;
        hs_n(K_CAL, 3);
        cal10 = 1'b0;
        hs_n(K_SW, 4);
        hs(K_ATU);

        // back to DTU
        TEST_ENABLE = 1'b0;
        hs_n(K_SW, 4);
        hs(K_DTU);

        // retarget mid-switch
        TEST_ENABLE = 1'b1;
        hs_n(K_SW, 2);
        TEST_ENABLE = 1'b0;
        hs_n(K_SW, 2);
        hs(K_DTU);

        // request pulse between handshakes is ignored
        TEST_ENABLE = 1'b1;
        repeat (2) @(negedge CLK);
        TEST_ENABLE = 1'b0;
        hs(K_DTU);

        // calibration from DTU returns to DTU through a full idle gap
        cal1 = 1'b1;
        hs(K_CAL);
        cal1 = 1'b0;
        hs_n(K_SW, 4);
        hs(K_DTU);

        // calibration rising during switch waits for the count, then wins
        TEST_ENABLE = 1'b1;
        hs(K_SW);
        cal1 = 1'b1;
        hs_n(K_SW, 3);
        hs(K_CAL);
        cal1 = 1'b0;
        hs_n(K_SW, 4);
        hs(K_ATU);
        TEST_ENABLE = 1'b0;
        hs_n(K_SW, 4);
        hs(K_DTU);

        // handshake held high: one handshake per cycle
        TEST_ENABLE = 1'b1;
        hs_n(K_SW, 4, 0);
        hs(K_ATU, 0);
        hs(K_ATU);

        // watchdog
        chk_bit("no_early_sync_err", sync_err, 1'b0);
        hs(K_ATU, 0);
        repeat (63) @(negedge CLK);
        chk_bit("wd_63_cycles", sync_err, 1'b0);
        @(negedge CLK);
        chk_bit("wd_64_cycles", sync_err, 1'b1);
        hs(K_ATU);
        chk_bit("wd_sticky", sync_err, 1'b1);
        rst_b = 1'b0;
        @(negedge CLK);
        chk_bit("wd_reset_clear", sync_err, 1'b0);
        rst_b = 1'b1;

        // reset mid-switch
        hs(K_SW);
        rst_b = 1'b0;
        TEST_ENABLE = 1'b0;
        @(negedge CLK);
        rst_b = 1'b1;
        repeat (2) @(negedge CLK);
        hs(K_DTU);
        hs(K_DTU);

        repeat (4) @(negedge CLK);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
